csa_accumulator: RTL

- Sequential multi-operand adder built from rows of 3:2 full-adder compressors. It is the parametrised successor of the single-bit full-adder cell in the Dadda multiplier datapath.
- Accepts a stream of WIDTH-bit operands terminated by a last flag and holds the running total in carry-save form, one operand per cycle.
- At end of stream it resolves the total with a chunked carry-propagate adder over several cycles, then presents the result on a valid/ready output.
- Used for partial-product accumulation and dot-product reduction.

---
 rtl/csa_accumulator_pkg.sv | 38 +++
 rtl/csa_accumulator_csa_row.sv | 18 +
 rtl/csa_accumulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/csa_accumulator_pkg.sv
// rtl/csa_accumulator_pkg.sv - shared types and sizing helpers for csa_accumulator.
// CSA_ACCUM_SIGNED_EN selects two's-complement operand extension.
package csa_accumulator_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  function automatic int calc_acc_w(input int width, input int max_ops);
    return width + $clog2(max_ops);
  endfunction

  function automatic int calc_cnt_w(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

  function automatic int calc_r(input int acc_w, input int chunk);
    return (acc_w + chunk - 1) / chunk;
  endfunction

  // Operands travel in a 64-bit container; callers truncate to ACC_W.
  function automatic logic [63:0] ext_operand(input logic [63:0] data, input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
`ifdef CSA_ACCUM_SIGNED_EN
    if (data[width-1]) begin
      return data | ~mask;
    end else begin
      return data & mask;
    end
`else
    return data & mask;
`endif
  endfunction

endpackage

// File: rtl/csa_accumulator_csa_row.sv
// rtl/csa_accumulator_csa_row.sv - one row of 3:2 compressors, carry pre-shifted.
module csa_row #(
  parameter int W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  logic [W-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save stream accumulator with chunked final resolve.
// Build with CSA_ACCUM_SIGNED_EN for signed operands (see package).
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 4,
  parameter int CHUNK   = 4,
  localparam int ACC_W  = calc_acc_w(WIDTH, MAX_OPS),
  localparam int CNT_W  = calc_cnt_w(MAX_OPS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_data,
  input  logic             io_in_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [ACC_W-1:0] io_out_sum,
  output logic [CNT_W-1:0] io_out_count,
  output logic             io_out_truncated
);

  localparam int R     = calc_r(ACC_W, CHUNK);
  localparam int IDX_W = $clog2(R + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d, trunc_q, trunc_d, in_ready_q, in_ready_d;

  logic [ACC_W-1:0] ext, row_sum, row_carry;
  logic [CHUNK-1:0] s_sl, c_sl;
  logic [CHUNK:0]   slice_sum;

  assign ext = ACC_W'(ext_operand(64'(io_in_data), WIDTH));

  csa_row #(.W(ACC_W)) u_row (
    .a_i    (s_q),
    .b_i    (c_q),
    .c_i    (ext),
    .sum_o  (row_sum),
    .carry_o(row_carry)
  );

  // Slices past the MSB read as zero, so the last narrow chunk needs no special case.
  assign s_sl      = CHUNK'(s_q >> (idx_q * CHUNK));
  assign c_sl      = CHUNK'(c_q >> (idx_q * CHUNK));
  assign slice_sum = {1'b0, s_sl} + {1'b0, c_sl} + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cy_d    = cy_q;
    trunc_d = trunc_q;
    case (state_q)
      ACCUM: begin
        if (io_in_valid && in_ready_q) begin
          s_d   = row_sum;
          c_d   = row_carry;
          cnt_d = cnt_q + CNT_W'(1);
          if (io_in_last || (cnt_q == CNT_W'(MAX_OPS - 1))) begin
            state_d = RESOLVE;
            trunc_d = !io_in_last;
            idx_d   = '0;
            cy_d    = 1'b0;
            sum_d   = '0;
          end
        end
      end
      RESOLVE: begin
        sum_d = sum_q | (ACC_W'(slice_sum[CHUNK-1:0]) << (idx_q * CHUNK));
        cy_d  = slice_sum[CHUNK];
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(R - 1)) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (io_out_ready) begin
          state_d = ACCUM;
          s_d     = '0;
          c_d     = '0;
          sum_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          cy_d    = 1'b0;
          trunc_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      s_q        <= '0;
      c_q        <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      cy_q       <= 1'b0;
      trunc_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      c_q        <= c_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      cy_q       <= cy_d;
      trunc_q    <= trunc_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign io_in_ready      = in_ready_q;
  assign io_out_valid     = (state_q == OUTPUT);
  assign io_out_sum       = sum_q;
  assign io_out_count     = cnt_q;
  assign io_out_truncated = trunc_q;

endmodule
